vga_scan_engine: RTL and testbench

- Parametrised successor to the fixed 640x480 VGA timing/address generator that fed `q[3:0]` into the colour DAC.
- Runs on one system clock and advances on a pixel-enable tick; no derived pixel clock.
- Generates programmable H/V timing and framebuffer read addresses with integer pixel replication and frame-latched scroll.
- Compensates a parametrised memory read latency and maps N-bit pixel data to 24-bit RGB through grayscale expansion or a writable palette.

---
 rtl/vga_scan_engine.sv | 165 ++++++++++++++++
 tb/tb_vga_scan_engine.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_engine.sv
// vga_scan_engine
//   Programmable VGA timing and framebuffer address generator. Advances only
//   on the pix_en tick, replicates each framebuffer pixel 2^SCALE times in
//   both directions, and applies a scroll offset latched at frame start. It
//   absorbs a MEM_LAT-tick memory read latency and produces 24-bit RGB either
//   by grayscale expansion of the pixel data or through a writable palette.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   pix_en              pixel tick; the counters and pipeline advance only when high
//   mode                0 = grayscale expansion, 1 = palette lookup
//   scroll_x/scroll_y   framebuffer offsets, sampled at frame start
//   pal_we/addr/wdata   palette write port (does not depend on pix_en)
//   address, mem_en     framebuffer read request (mem_en mirrors pix_en)
//   data                framebuffer read data, MEM_LAT ticks after address
//   hsync, vsync        sync outputs, aligned with r/g/b
//   blank_b, sync_b     high while visible / tied low
//   r, g, b             colour outputs
//   frame_start         one-clock pulse on the first tick of each frame
module vga_scan_engine #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int SCALE    = 0,
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 24,
  parameter int MEM_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  input  logic              mode,
  input  logic [15:0]       scroll_x,
  input  logic [15:0]       scroll_y,
  input  logic              pal_we,
  input  logic [DATA_W-1:0] pal_addr,
  input  logic [23:0]       pal_wdata,
  output logic [ADDR_W-1:0] address,
  output logic              mem_en,
  input  logic [DATA_W-1:0] data,
  output logic              hsync,
  output logic              vsync,
  output logic              blank_b,
  output logic              sync_b,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned FB_W    = H_ACTIVE >> SCALE;
  localparam int unsigned FB_H    = V_ACTIVE >> SCALE;
  localparam int          HC_W    = $clog2(H_TOTAL);
  localparam int          VC_W    = $clog2(V_TOTAL);
  localparam int          DEPTH   = MEM_LAT + 2;
  localparam int          PAL_N   = 1 << DATA_W;

  // Left-justify the pixel value and refill the low bits with its MSBs,
  // so all-ones expands to 0xFF.
  function automatic logic [7:0] expand(input logic [DATA_W-1:0] d);
    logic [7:0] e;
    e = '0;
    for (int i = 0; i < 8; i++) e[7-i] = d[DATA_W-1-(i % DATA_W)];
    return e;
  endfunction

  // Offset modulo n using at most one subtraction; anything >= 2n clamps to 0.
  function automatic logic [15:0] wrap_scroll(input logic [15:0] v, input int unsigned n);
    logic [31:0] w;
    w = 32'(v);
    if (w < n)          return v;
    else if (w < 2 * n) return 16'(w - n);
    else                return '0;
  endfunction

  logic [HC_W-1:0]   hc_q, hc_d;
  logic [VC_W-1:0]   vc_q, vc_d;
  logic [15:0]       sx_q, sy_q, sx_d, sy_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [2:0]        pipe_q [DEPTH];   // {active, hs_raw, vs_raw}
  logic [23:0]       rgb_q, rgb_d;
  logic              frame_start_q;
  logic [23:0]       pal_q [PAL_N];

  logic        active, hs_raw, vs_raw, at_origin;
  logic [31:0] hc32, vc32, px, py, addr32;

  always_comb begin
    hc32      = 32'(hc_q);
    vc32      = 32'(vc_q);
    active    = (hc32 < H_ACTIVE) && (vc32 < V_ACTIVE);
    hs_raw    = (hc32 >= H_ACTIVE + H_FP) && (hc32 < H_ACTIVE + H_FP + H_SYNC) ? HS_POL : !HS_POL;
    vs_raw    = (vc32 >= V_ACTIVE + V_FP) && (vc32 < V_ACTIVE + V_FP + V_SYNC) ? VS_POL : !VS_POL;
    at_origin = pix_en && (hc_q == '0) && (vc_q == '0);

    // The first pixel of a frame must already use the freshly latched scroll.
    sx_d = at_origin ? wrap_scroll(scroll_x, FB_W) : sx_q;
    sy_d = at_origin ? wrap_scroll(scroll_y, FB_H) : sy_q;

    px = (hc32 >> SCALE) + 32'(sx_d);
    if (px >= FB_W) px = px - FB_W;
    py = (vc32 >> SCALE) + 32'(sy_d);
    if (py >= FB_H) py = py - FB_H;
    addr32    = py * FB_W + px;
    address_d = active ? addr32[ADDR_W-1:0] : address_q;

    hc_d = hc_q + 1'b1;
    vc_d = vc_q;
    if (hc32 == H_TOTAL - 1) begin
      hc_d = '0;
      vc_d = (vc32 == V_TOTAL - 1) ? '0 : vc_q + 1'b1;
    end

    // pipe_q[MEM_LAT] carries the visibility of the pixel whose data is on the bus now.
    if (!pipe_q[MEM_LAT][2]) rgb_d = '0;
    else if (mode)           rgb_d = pal_q[data];
    else                     rgb_d = {3{expand(data)}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hc_q          <= '0;
      vc_q          <= '0;
      sx_q          <= '0;
      sy_q          <= '0;
      address_q     <= '0;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= {1'b0, !HS_POL, !VS_POL};
      for (int i = 0; i < PAL_N; i++) pal_q[i] <= {3{expand(DATA_W'(i))}};
    end else begin
      frame_start_q <= at_origin;
      if (pix_en) begin
        hc_q      <= hc_d;
        vc_q      <= vc_d;
        sx_q      <= sx_d;
        sy_q      <= sy_d;
        address_q <= address_d;
        rgb_q     <= rgb_d;
        pipe_q[0] <= {active, hs_raw, vs_raw};
        for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
      end
      if (pal_we) pal_q[pal_addr] <= pal_wdata;
    end
  end

  assign address    = address_q;
  assign mem_en     = pix_en;
  assign hsync      = pipe_q[DEPTH-1][1];
  assign vsync      = pipe_q[DEPTH-1][0];
  assign blank_b    = pipe_q[DEPTH-1][2];
  assign sync_b     = 1'b0;
  assign {r, g, b}  = rgb_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scan_engine.sv
// Testbench for vga_scan_engine on a small 8x4 visible raster (14x7 total)
// with 2x pixel replication. A reference model driven by tick numbers
// computes each pixel's expected pins, a queue holds them, and a monitor on
// the falling edge compares every clock.
module tb_vga_scan_engine;

  localparam int HA = 8,  HFP = 2, HSW = 2, HBP = 2;
  localparam int VA = 4,  VFP = 1, VSW = 1, VBP = 1;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int SC = 1;
  localparam int FBW = HA >> SC, FBH = VA >> SC;
  localparam int ML = 1;

  logic        clk = 1'b0;
  logic        rst, pix_en, mode, pal_we;
  logic [15:0] scroll_x, scroll_y;
  logic [3:0]  pal_addr;
  logic [23:0] pal_wdata;
  logic [23:0] address;
  logic        mem_en;
  logic [3:0]  data;
  logic        hsync, vsync, blank_b, sync_b, frame_start;
  logic [7:0]  r, g, b;

  always #5 clk = ~clk;

  vga_scan_engine #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .SCALE(SC), .DATA_W(4), .ADDR_W(24), .MEM_LAT(ML)
  ) u_dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .mode(mode),
    .scroll_x(scroll_x), .scroll_y(scroll_y),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
    .address(address), .mem_en(mem_en), .data(data),
    .hsync(hsync), .vsync(vsync), .blank_b(blank_b), .sync_b(sync_b),
    .r(r), .g(g), .b(b), .frame_start(frame_start)
  );

  // Framebuffer contents: a scrambled ramp so every address maps to a distinct word.
  function automatic logic [3:0] mem_word(input int unsigned a);
    int unsigned t;
    t = a * 3 + 9;
    return t[3:0];
  endfunction

  // Memory with ML ticks of read latency, stepping only on mem_en.
  logic [3:0] mem_pipe [ML];
  initial for (int i = 0; i < ML; i++) mem_pipe[i] = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      mem_pipe[0] <= mem_word(32'(address));
      for (int i = 1; i < ML; i++) mem_pipe[i] <= mem_pipe[i-1];
    end
  end
  assign data = mem_pipe[ML-1];

  typedef struct packed { logic vis; logic hs; logic vs; logic [3:0] d; } tick_t;
  typedef struct packed { logic hs; logic vs; logic bl; logic fs; logic [23:0] rgb; } out_t;

  tick_t       pend [$];
  out_t        exp_q [$];
  out_t        last_e;
  logic [23:0] m_pal [16];
  int          m_tick;
  int          m_sx, m_sy;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [23:0] gray(input int v);
    logic [7:0] c;
    c = 8'(v * 17);
    return {c, c, c};
  endfunction

  // Model of one clock edge using the inputs currently applied.
  task automatic model_edge();
    out_t  e;
    tick_t t, o;
    int    hc, vc, px, py;
    if (rst) begin
      m_tick = 0; m_sx = 0; m_sy = 0;
      pend.delete();
      for (int i = 0; i < ML + 1; i++) pend.push_back('{vis:1'b0, hs:1'b1, vs:1'b1, d:4'd0});
      for (int i = 0; i < 16; i++) m_pal[i] = gray(i);
      e = '{hs:1'b1, vs:1'b1, bl:1'b0, fs:1'b0, rgb:24'd0};
    end else begin
      e = last_e;
      e.fs = 1'b0;
      if (pix_en) begin
        hc = m_tick % HT;
        vc = (m_tick / HT) % VT;
        if (hc == 0 && vc == 0) begin
          e.fs = 1'b1;
          m_sx = (int'(scroll_x) < 2 * FBW) ? int'(scroll_x) % FBW : 0;
          m_sy = (int'(scroll_y) < 2 * FBH) ? int'(scroll_y) % FBH : 0;
        end
        px = ((hc >> SC) + m_sx) % FBW;
        py = ((vc >> SC) + m_sy) % FBH;
        t.vis = (hc < HA) && (vc < VA);
        t.hs  = !((hc >= HA + HFP) && (hc < HA + HFP + HSW));
        t.vs  = !((vc >= VA + VFP) && (vc < VA + VFP + VSW));
        t.d   = mem_word(32'(py * FBW + px));
        pend.push_back(t);
        o = pend.pop_front();
        e.hs  = o.hs;
        e.vs  = o.vs;
        e.bl  = o.vis;
        e.rgb = !o.vis ? 24'd0 : (mode ? m_pal[o.d] : gray(int'(o.d)));
        m_tick++;
      end
      if (pal_we) m_pal[pal_addr] = pal_wdata;
    end
    last_e = e;
    exp_q.push_back(e);
  endtask

  task automatic cycle();
    #1;
    n_checks++;
    if (mem_en !== pix_en) begin
      n_fail++;
      $display("FAIL mem_en t=%0t got %b expected %b", $time, mem_en, pix_en);
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic run(input int n, input int period);
    for (int i = 0; i < n; i++) begin
      pix_en = ((i % period) == 0);
      cycle();
    end
  endtask

  always @(negedge clk) begin
    out_t e, got;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      got = {hsync, vsync, blank_b, frame_start, r, g, b};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL pins t=%0t got hs=%b vs=%b bl=%b fs=%b rgb=%06h expected hs=%b vs=%b bl=%b fs=%b rgb=%06h",
                 $time, got.hs, got.vs, got.bl, got.fs, got.rgb, e.hs, e.vs, e.bl, e.fs, e.rgb);
      end
      n_checks++;
      if (sync_b !== 1'b0) begin
        n_fail++;
        $display("FAIL sync_b t=%0t got %b expected 0", $time, sync_b);
      end
    end
  end

  initial begin
    rst = 1'b1; pix_en = 1'b0; mode = 1'b0; pal_we = 1'b0;
    pal_addr = '0; pal_wdata = '0; scroll_x = '0; scroll_y = '0;
    cycle();
    rst = 1'b0;

    // Two frames of plain grayscale, pix_en every clock.
    run(2 * HT * VT, 1);

    // Scroll latched at the frame start, a mid-frame change, then an out-of-range value.
    scroll_x = 16'd3; scroll_y = 16'd1;
    run(40, 1);
    scroll_x = 16'd1;
    run(HT * VT - 40 + HT * VT, 1);
    scroll_x = 16'd9; scroll_y = 16'd5;
    run(HT * VT, 1);

    // Palette entry 5 then lookups; then rewrite entry 5 every clock so writes collide with reads.
    scroll_x = 16'd0; scroll_y = 16'd0;
    mode = 1'b1; pal_we = 1'b1; pal_addr = 4'd5; pal_wdata = 24'h12AB34;
    pix_en = 1'b1;
    cycle();
    pal_we = 1'b0;
    run(HT * VT, 1);
    for (int i = 0; i < HT * VT; i++) begin
      pal_we = 1'b1; pal_addr = 4'd5; pal_wdata = 24'($urandom);
      pix_en = 1'b1;
      cycle();
    end
    pal_we = 1'b0;

    // Slow tick: one pix_en every 4 clocks.
    mode = 1'b0;
    run(4 * HT * VT, 4);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 1200; i++) begin
      pix_en = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      if ($urandom_range(0, 40) == 0) scroll_x = 16'($urandom_range(0, 11));
      if ($urandom_range(0, 40) == 0) scroll_y = 16'($urandom_range(0, 6));
      pal_we    = ($urandom_range(0, 3) == 0);
      pal_addr  = 4'($urandom_range(0, 15));
      pal_wdata = 24'($urandom);
      rst       = ($urandom_range(0, 399) == 0);
      cycle();
      rst = 1'b0;
    end
    pal_we = 1'b0;

    // Reset at hc=5, vc=2 and confirm the grayscale palette is back.
    rst = 1'b1; pix_en = 1'b1;
    cycle();
    rst = 1'b0; mode = 1'b1; scroll_x = 16'd2; scroll_y = 16'd0;
    run(2 * HT + 5, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run(2 * HT * VT, 1);

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
